// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed seven-segment display.
// Anodes are active-low; digit 0 is the rightmost nibble of the displayed value.
package seven_seg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int IDX_W      = 2;
   localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

   localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

   typedef logic [IDX_W-1:0]      idx_t;
   typedef logic [VALUE_W-1:0]    hexval_t;
   typedef logic [DIGIT_W-1:0]    digit_t;
   typedef logic [NUM_DIGITS-1:0] anode_t;

   // One-hot-low anode pattern for a slot.
   function automatic anode_t anode_sel(input idx_t idx);
      anode_sel = ~(anode_t'(1) << idx);
   endfunction

   // True when every digit from slot idx upward is zero; slot 0 always shows.
   function automatic logic lead_zero(input hexval_t v, input idx_t idx);
      case (idx)
         2'd1:    lead_zero = (v[15:4] == 12'h000);
         2'd2:    lead_zero = (v[15:8] == 8'h00);
         2'd3:    lead_zero = (v[15:12] == 4'h0);
         default: lead_zero = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider: tick_o is high for one cycle every DIV cycles (every cycle when DIV=1).
// Synchronous active-high reset returns the count to zero.
module refresh_prescaler #(
   parameter int unsigned DIV = 100000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Scans a 16-bit hex value across four digits, one nibble and one active-low anode per slot.
// New values are shadowed and swapped in only when the slot index wraps 3->0.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int unsigned DIV = 100000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [VALUE_W-1:0]    value_i,
   input  logic                  lz_en_i,
   output logic [DIGIT_W-1:0]    nibble_o,
   output logic [NUM_DIGITS-1:0] an_o,
   output logic                  blank_o,
   output logic                  pending_o,
   output logic                  frame_o
);

   logic    tick;
   logic    wrap;

   idx_t    idx_q,   idx_d;
   hexval_t disp_q,  disp_d;
   hexval_t shad_q,  shad_d;
   logic    pend_q,  pend_d;
   logic    frame_q, frame_d;

   refresh_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .tick_o (tick)
   );

   assign wrap = tick && (idx_q == idx_t'(NUM_DIGITS - 1));

   // The swap reads the pre-edge shadow, so a load on the wrap edge stays pending.
   always_comb begin
      idx_d   = idx_q;
      disp_d  = disp_q;
      shad_d  = shad_q;
      pend_d  = pend_q;
      frame_d = wrap;
      if (tick) begin
         idx_d = idx_q + idx_t'(1);
      end
      if (wrap && pend_q) begin
         disp_d = shad_q;
         pend_d = 1'b0;
      end
      if (load_i) begin
         shad_d = value_i;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q   <= '0;
         disp_q  <= '0;
         shad_q  <= '0;
         pend_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         disp_q  <= disp_d;
         shad_q  <= shad_d;
         pend_q  <= pend_d;
         frame_q <= frame_d;
      end
   end

   always_comb begin
      blank_o   = lz_en_i && lead_zero(disp_q, idx_q);
      nibble_o  = disp_q[{idx_q, 2'b00} +: DIGIT_W];
      an_o      = blank_o ? AN_OFF : anode_sel(idx_q);
      pending_o = pend_q;
      frame_o   = frame_q;
   end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Time-multiplexed scan controller for the 4-digit seven-segment display. It sits directly upstream of `SevenSegmentDecoder`. It holds a 16-bit value from the adder/subtractor datapath and steps through its four hex digits, presenting one nibble at a time on the decoder's 4-bit input while driving the matching active-low anode. New values are double-buffered and applied only at frame boundaries, so a digit never shows a partially updated value.

## Interface
- `DIV`, 100000, clock cycles per digit slot; legal range ≥ 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `load`  in  1  single-cycle strobe; captures `value` into the shadow register.
- `value`  in  16  hex value to display; digit 0 = `value[3:0]` (rightmost).
- `lz_en`  in  1  leading-zero suppression enable; sampled continuously.
- `nibble`  out  4  hex digit for the active slot; connects to decoder `in`.
- `an`  out  4  anode enables, active-low, one-hot-low; all ones when blanked.
- `blank`  out  1  high when the active digit is suppressed.
- `pending`  out  1  shadow register holds a value not yet displayed.
- `frame`  out  1  one-cycle pulse on the edge where the slot index wraps from 3 to 0.

## Operation
- Registers:
  - prescaler `cnt`, counts 0..DIV-1.
  - slot index `idx`, 2 bits.
  - display register `disp`, 16 bits.
  - shadow register `shad`, 16 bits.
  - `pending` flag.
  - `frame` pulse register.
- Reset values: cnt=0, idx=0, disp=0, shad=0, pending=0, frame=0. Therefore after reset `an`=4'b1110, `nibble`=0, `blank`=0.
- `tick` = (cnt==DIV-1). On tick, cnt returns to 0 and idx advances by 1 mod 4. Otherwise cnt increments.
- Frame wrap: tick with idx==3. On that edge:
  - frame is set to 1 for one cycle.
  - If pending==1 before the edge, disp loads shad and pending clears.
- `load`: shad ← value and pending ← 1, on any edge without rst.
  - Load while pending: last value wins.
  - Load on a frame-wrap edge: the swap uses the pre-edge contents of shad. The new value stays in shad and pending remains 1. If pending was 0 before that edge, no swap occurs and pending becomes 1.
- Outputs are combinational functions of registers only; no input-to-output paths except via registers.
  - `nibble` = disp[4·idx +: 4].
  - `an` = ~(1<<idx) unless blank.
- Blanking, when lz_en=1: digit k (k=1..3) is blank iff disp[15:4k]==0. Digit 0 is never blanked, so value 0 shows a single "0".
  - When blank: `an`=4'b1111 and `nibble` still shows the digit, which is 0.
  - When lz_en=0: blank is always 0.

## Timing
- A digit slot lasts exactly DIV cycles. A frame lasts 4·DIV cycles.
- `an`/`nibble`/`blank` change on the same edge idx changes, with no intermediate states.
- Load-to-display latency: from the load edge to the next frame-wrap edge, between 1 and 4·DIV cycles. The new digit 0 appears on that wrap edge.
- DIV=1: tick every cycle; idx cycles 0,1,2,3 on consecutive edges; frame pulses every 4th cycle.
- rst mid-frame: all registers return to their reset values on that edge, and any pending value is discarded. Priority is rst > swap > load.

## Structure
- Shared include/package `seven_seg_pkg`:
  - `NUM_DIGITS`=4.
  - `AN_OFF`=4'b1111.
  - `DIGIT_W`=4.
- One sub-module `refresh_prescaler`:
  - Parameter DIV; ports clk, rst, `tick` out.
  - Reused by any other scanned display in the codebase.
- Top-level connection: seven_seg_scan.nibble → SevenSegmentDecoder.in. The anodes go straight to the board.

## Test plan
- Reset, DIV=4, no load → an=1110, nibble=0, pending=0. After 4 cycles an=1101; frame pulses at cycle 16.
- load value=16'h1A3F at cycle 2 → pending=1 immediately. On the wrap at cycle 16: disp=1A3F, pending=0. Then nibbles F,3,A,1 with an 1110,1101,1011,0111, each held 4 cycles.
- lz_en=1 with value=16'h0005 → digit 0 shows nibble 5 with an=1110. Slots 1–3 have blank=1 and an=1111. Value 16'h0000 → only digit 0 lit, showing 0.
- load 16'h1111 then 16'h2222 in the same frame → only 2222 is displayed after the wrap. load of 16'h3333 on the wrap edge itself → 2222 is shown, pending stays 1, and 3333 appears on the next wrap.
- rst asserted for one cycle in slot 2 with pending=1 → next cycle idx=0, an=1110, disp=0, pending=0. The discarded value never appears.
- DIV=1 → idx sequence 0,1,2,3,0 on consecutive edges; frame high every 4th cycle.
